// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-counter width calculation.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 0..w-1; a single bit is still needed when w is 1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit combinational full adder cell, the only arithmetic in the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts a, b, carry_in on a valid/ready handshake,
// adds one bit per clock LSB first, and returns sum/carry_out on a second handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_shift;

  fa_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
  always_comb begin
    sum_shift            = sum_sr_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d     = a;
          b_sr_d     = b;
          carry_d    = carry_in;
          cnt_d      = '0;
          state_d    = ADD;
          in_ready_d = 1'b0;
        end
      end
      ADD: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sr_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main sequence and
// a 1-bit instance for the degenerate width.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, carry_in, out_valid, out_ready, carry_out;
  logic [7:0] a, b, sum;

  logic       in_valid1, in_ready1, carry_in1, out_valid1, out_ready1, carry_out1;
  logic [0:0] a1, b1, sum1;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .carry_in  (carry_in1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .carry_out (carry_out1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one 8-bit operation, scramble the inputs afterwards, and wait for DONE.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv, input logic [7:0] es, input logic ec);
    in_valid = 1'b1; a = av; b = bv; carry_in = cv;
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv; carry_in = ~cv;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_co"}, 32'(carry_out), 32'(ec));
    chk({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; carry_in1 = 1'b0; out_ready1 = 1'b1;
    #1;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_inrdy", 32'(in_ready), 32'd1);
    chk("rel_ovld", 32'(out_valid), 32'd0);
    chk("rel_sum", 32'(sum), 32'h00);
    chk("rel_co", 32'(carry_out), 32'd0);
    chk("rel1_inrdy", 32'(in_ready1), 32'd1);
    chk("rel1_ovld", 32'(out_valid1), 32'd0);

    // Plain add with out_ready high: DONE lasts one cycle.
    op8("add3c05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    @(negedge clk);
    chk("add3c05_ovld_drop", 32'(out_valid), 32'd0);
    chk("add3c05_inrdy_back", 32'(in_ready), 32'd1);

    op8("addff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    @(negedge clk);
    chk("addff00c_inrdy_back", 32'(in_ready), 32'd1);

    op8("addffffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    chk("addffffc_inrdy_back", 32'(in_ready), 32'd1);

    // Back-pressure: hold DONE for 5 cycles with a competing request present.
    out_ready = 1'b0;
    op8("bp", 8'h80, 8'h90, 1'b0, 8'h10, 1'b1);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ovld_hold", 32'(out_valid), 32'd1);
      chk("bp_sum_hold", 32'(sum), 32'h10);
      chk("bp_co_hold", 32'(carry_out), 32'd1);
      chk("bp_inrdy_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_ovld_drop", 32'(out_valid), 32'd0);
    chk("bp_inrdy_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_accept", 32'(in_ready), 32'd1);

    // Reset on the 4th ADD edge of an operation.
    in_valid = 1'b1; a = 8'h55; b = 8'h33; carry_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_inrdy", 32'(in_ready), 32'd1);
    chk("mid_rst_ovld", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'h00);
    chk("mid_rst_co", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("mid_rst_no_ovld", 32'(seen), 32'd0);
    chk("mid_rst_idle", 32'(in_ready), 32'd1);
    op8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    @(negedge clk);
    chk("after_rst_inrdy_back", 32'(in_ready), 32'd1);

    // One-bit instance: 1 + 1 + 1 = 3 -> sum 1, carry 1, one ADD edge.
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; carry_in1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; carry_in1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_lat", 32'(lat), 32'd1);
    chk("w1_sum", 32'(sum1), 32'd1);
    chk("w1_co", 32'(carry_out1), 32'd1);
    @(negedge clk);
    chk("w1_ovld_drop", 32'(out_valid1), 32'd0);
    chk("w1_inrdy_back", 32'(in_ready1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
